// File: rtl/mag_bar_display.sv
// rtl/mag_bar_display.sv - LED bar-graph driver for decimated magnitude samples
//
// Purpose: decimates magnitude samples by windowed maximum and renders them
// on an LED bar in RAW, linear, log or linear+decaying-peak-marker mode.
//
// Ports:
//   sys_clk     in  1        clock, rising edge
//   rst_n       in  1        synchronous active-low reset
//   mag_in      in  MAG_W    magnitude sample
//   mag_rdy     in  1        mag_in valid strobe
//   mode        in  2        00 RAW, 01 LIN, 10 LOG, 11 PEAK
//   decim       in  DECIM_W  window length minus 1
//   hold_cycles in  HOLD_W   cycles the peak holds per decay step
//   leds        out LED_N    display, bit 0 = bottom of bar
//   upd         out 1        pulse in the cycle after leds was written
module mag_bar_display #(
   parameter int MAG_W   = 16,
   parameter int LED_N   = 8,
   parameter int DECIM_W = 8,
   parameter int HOLD_W  = 16
) (
   input  logic               sys_clk,
   input  logic               rst_n,
   input  logic [MAG_W-1:0]   mag_in,
   input  logic               mag_rdy,
   input  logic [1:0]         mode,
   input  logic [DECIM_W-1:0] decim,
   input  logic [HOLD_W-1:0]  hold_cycles,
   output logic [LED_N-1:0]   leds,
   output logic               upd
);
   localparam int LOG2N = $clog2(LED_N);
   localparam int LW    = LOG2N + 1;

   logic [DECIM_W-1:0] cnt;
   logic [MAG_W-1:0]   wmax;
   logic [MAG_W-1:0]   win;
   logic [MAG_W-1:0]   m;
   logic [LW-1:0]      peak;
   logic [HOLD_W-1:0]  hcnt;
   logic [LW-1:0]      lvl;
   logic [LW-1:0]      llv;
   logic [LW-1:0]      acc_lvl;
   logic [LED_N-1:0]   marker;
   logic               accept;
   logic               decay_step;
   logic               rend_acc;
   logic               rend_dec;

   function automatic logic [LW-1:0] lin_level(input logic [MAG_W-1:0] v);
      logic [MAG_W-1:0] sh;
      sh = v >> (MAG_W - LOG2N);
      if (v == '0) return '0;
      return sh[LW-1:0] + LW'(1);
   endfunction

   function automatic logic [LW-1:0] log_level(input logic [MAG_W-1:0] v);
      int msb;
      int l;
      msb = 0;
      for (int i = 0; i < MAG_W; i++) begin
         if (v[i]) msb = i;
      end
      l = msb + 1 - (MAG_W - LED_N);
      if (v == '0 || l < 0) return '0;
      if (l > LED_N) return LW'(LED_N);
      return LW'(l);
   endfunction

   function automatic logic [LED_N-1:0] bar(input logic [LW-1:0] n);
      logic [LED_N-1:0] b;
      for (int i = 0; i < LED_N; i++) begin
         b[i] = (i < int'(n));
      end
      return b;
   endfunction

   assign m       = (mag_in > wmax) ? mag_in : wmax;
   // >= so that lowering decim mid-window accepts immediately instead of wrapping
   assign accept  = mag_rdy && (cnt >= decim);
   assign acc_lvl = lin_level(m);
   assign lvl     = lin_level(win);
   assign llv     = log_level(win);
   // An accept in the same cycle suppresses decay expiry
   assign decay_step = !accept && (peak != '0) && (hcnt == '0);

   always_comb begin
      marker = '0;
      for (int i = 0; i < LED_N; i++) begin
         marker[i] = (peak != '0) && (i == int'(peak) - 1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         cnt      <= '0;
         wmax     <= '0;
         win      <= '0;
         peak     <= '0;
         hcnt     <= '0;
         leds     <= '0;
         upd      <= 1'b0;
         rend_acc <= 1'b0;
         rend_dec <= 1'b0;
      end else begin
         if (mag_rdy) begin
            if (accept) begin
               win  <= m;
               wmax <= '0;
               cnt  <= '0;
            end else begin
               wmax <= m;
               cnt  <= cnt + DECIM_W'(1);
            end
         end

         // Peak tracker runs on the level of the value being accepted
         if (accept && (acc_lvl >= peak || hold_cycles == '0)) begin
            peak <= acc_lvl;
            hcnt <= hold_cycles;
         end else if (!accept && peak != '0) begin
            if (hcnt == '0) begin
               peak <= peak - LW'(1);
               hcnt <= hold_cycles;
            end else begin
               hcnt <= hcnt - HOLD_W'(1);
            end
         end

         // Render one edge after win or peak changed
         rend_acc <= accept;
         rend_dec <= decay_step;
         upd      <= 1'b0;
         if (rend_acc || (rend_dec && mode == 2'b11)) begin
            upd <= 1'b1;
            case (mode)
               2'b00:   leds <= win[MAG_W-1 -: LED_N];
               2'b01:   leds <= bar(lvl);
               2'b10:   leds <= bar(llv);
               default: leds <= bar(lvl) | marker;
            endcase
         end
      end
   end
endmodule
